epu_layer_sequencer: RTL and testbench

- Sequences the EPU compute units (3x3 conv, 1x1 conv, max pool) one layer at a time.
- Owns the 4-bit one-hot mode that drives the bus switcher, which selects the unit connected to the shared param/bias/weight/input/output SRAM buses.
- Owns the per-unit clock-gating enables.
- Takes layer descriptors from a small internal FIFO, switches the buses, lets them settle, starts the selected unit, waits for its done, then returns the buses to IDLE before the next layer.

---
 rtl/epu_layer_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_epu_layer_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epu_layer_sequencer.sv
// EPU layer sequencer: descriptor FIFO, one-hot bus-switch mode, unit clock-gate enables
// and start/done handshake. Define EPU_SEQ_TIMEOUT_EN to build the RUN-state watchdog.
module epu_layer_sequencer #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TAG_W       = 8,
   parameter int unsigned SETTLE_CYC  = 2,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             desc_valid,
   output logic             desc_ready,
   input  logic [1:0]       desc_op,
   input  logic [TAG_W-1:0] desc_tag,
   input  logic             abort,
   input  logic             conv_3x3_done,
   input  logic             conv_1x1_done,
   input  logic             maxpool_done,
   output logic [3:0]       mode,
   output logic             conv_3x3_en,
   output logic             conv_1x1_en,
   output logic             maxpool_en,
   output logic             unit_start,
   output logic             busy,
   output logic             layer_done,
   output logic [TAG_W-1:0] done_tag,
   output logic             err_illegal,
   output logic             timeout
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [3:0]  MODE_IDLE = 4'b0001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SWITCH,
      S_START,
      S_RUN,
      S_DRAIN
   } state_t;

   typedef struct packed {
      logic [1:0]       op;
      logic [TAG_W-1:0] tag;
   } desc_t;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("epu_layer_sequencer: illegal parameter value");
   end

   state_t           state, state_nxt;
   logic [1:0]       cur_op, op_nxt;
   logic [TAG_W-1:0] cur_tag;
   logic [SET_W-1:0] settle_cnt;
   logic             done_pend;
   logic             done_sel;
   logic             done_hit;
   logic             expire;
   logic [3:0]       mode_nxt;

   desc_t            fifo_mem [FIFO_DEPTH];
   desc_t            head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic             push, pop, empty;

   assign head  = fifo_mem[rd_ptr];
   assign empty = (count == '0);
   assign push  = desc_valid && desc_ready && !abort;
   assign pop   = (state == S_IDLE) && !empty && !abort;
   assign busy  = (state != S_IDLE) || !empty;

   always_comb begin
      count_nxt = count;
      if (abort)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + CNT_W'(1);
      else if (pop && !push)
         count_nxt = count - CNT_W'(1);
   end

   // NOTE: the descriptor storage has no reset; an entry is only read after it was written,
   // so a reset would only add a reset tree to the array.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{op: desc_op, tag: desc_tag};
   end

   // NOTE: all state in clocked processes uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         desc_ready <= 1'b1;
      end else begin
         count      <= count_nxt;
         desc_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
         if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Only the done of the unit owning the buses is honoured.
   always_comb begin
      done_sel = 1'b0;
      case (cur_op)
         2'd0:    done_sel = conv_3x3_done;
         2'd1:    done_sel = conv_1x1_done;
         2'd2:    done_sel = maxpool_done;
         default: done_sel = 1'b0;
      endcase
   end

   assign done_hit = (state == S_RUN) && (done_sel || done_pend);

`ifdef EPU_SEQ_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         wd_cnt <= '0;
      else if (state != S_RUN)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + WD_W'(1);
   end

   // Expires on the TIMEOUT_CYC-th RUN cycle; a done in that same cycle takes precedence.
   assign expire = (state == S_RUN) && !done_hit && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
   assign expire = 1'b0;
`endif

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      state_nxt = state;
      op_nxt    = pop ? head.op : cur_op;
      case (state)
         S_IDLE:   if (pop && head.op != 2'd3) state_nxt = S_SWITCH;
         S_SWITCH: if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = S_START;
         S_START:  state_nxt = S_RUN;
         S_RUN:    if (done_hit || expire) state_nxt = S_DRAIN;
         S_DRAIN:  state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (abort)
         state_nxt = S_IDLE;

      mode_nxt = MODE_IDLE;
      if (state_nxt inside {S_SWITCH, S_START, S_RUN}) begin
         case (op_nxt)
            2'd0:    mode_nxt = 4'b0010;
            2'd1:    mode_nxt = 4'b0100;
            2'd2:    mode_nxt = 4'b1000;
            default: mode_nxt = MODE_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         cur_op      <= '0;
         cur_tag     <= '0;
         settle_cnt  <= '0;
         done_pend   <= 1'b0;
         mode        <= MODE_IDLE;
         conv_3x3_en <= 1'b0;
         conv_1x1_en <= 1'b0;
         maxpool_en  <= 1'b0;
         unit_start  <= 1'b0;
         layer_done  <= 1'b0;
         err_illegal <= 1'b0;
         timeout     <= 1'b0;
         done_tag    <= '0;
      end else begin
         state <= state_nxt;
         mode  <= mode_nxt;
         {maxpool_en, conv_1x1_en, conv_3x3_en} <= mode_nxt[3:1];
         unit_start <= (state_nxt == S_START);

         if (pop) begin
            cur_op  <= head.op;
            cur_tag <= head.tag;
         end

         settle_cnt <= (state == S_SWITCH) ? settle_cnt + SET_W'(1) : '0;
         // A done seen in START is remembered so RUN exits on its first cycle.
         done_pend   <= (state == S_START) && done_sel && !abort;
         layer_done  <= done_hit && !abort;
         timeout     <= expire && !abort;
         err_illegal <= pop && (head.op == 2'd3);

         if (pop && head.op == 2'd3)
            done_tag <= head.tag;
         else if ((done_hit || expire) && !abort)
            done_tag <= cur_tag;
      end
   end

endmodule

// File: tb/tb_epu_layer_sequencer.sv
// Scoreboard bench for epu_layer_sequencer: directed descriptors, modelled unit done responses,
// and a monitor that checks every completion/error/timeout event against the expected queue.
module tb_epu_layer_sequencer;

   localparam int TAG_W  = 8;
   localparam int TO_CYC = 10;

   logic             clk;
   logic             rstn;
   logic             desc_valid;
   logic             desc_ready;
   logic [1:0]       desc_op;
   logic [TAG_W-1:0] desc_tag;
   logic             abort;
   logic             conv_3x3_done, conv_1x1_done, maxpool_done;
   logic [3:0]       mode;
   logic             conv_3x3_en, conv_1x1_en, maxpool_en;
   logic             unit_start, busy, layer_done, err_illegal, timeout;
   logic [TAG_W-1:0] done_tag;

   logic             resp_3x3, resp_1x1, resp_mp, stray_3x3;

   assign conv_3x3_done = resp_3x3 | stray_3x3;
   assign conv_1x1_done = resp_1x1;
   assign maxpool_done  = resp_mp;

   epu_layer_sequencer #(
      .FIFO_DEPTH (4),
      .TAG_W      (TAG_W),
      .SETTLE_CYC (2),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .desc_valid   (desc_valid),
      .desc_ready   (desc_ready),
      .desc_op      (desc_op),
      .desc_tag     (desc_tag),
      .abort        (abort),
      .conv_3x3_done(conv_3x3_done),
      .conv_1x1_done(conv_1x1_done),
      .maxpool_done (maxpool_done),
      .mode         (mode),
      .conv_3x3_en  (conv_3x3_en),
      .conv_1x1_en  (conv_1x1_en),
      .maxpool_en   (maxpool_en),
      .unit_start   (unit_start),
      .busy         (busy),
      .layer_done   (layer_done),
      .done_tag     (done_tag),
      .err_illegal  (err_illegal),
      .timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {EV_DONE = 0, EV_ERR = 1, EV_TMO = 2, EV_NONE = 3} ev_kind_t;

   typedef struct {
      ev_kind_t         kind;
      logic [TAG_W-1:0] tag;
   } ev_t;

   typedef struct {
      logic [1:0] op;
      bit         resp;
      int         delay;
   } start_t;

   ev_t    ev_q[$];
   start_t start_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / unit responder ----------------
   int         cyc       = 0;
   int         start_cyc = 0;
   int         lat_exp   = 0;
   int         resp_cnt  = 0;
   logic [1:0] resp_op   = 2'd0;
   logic [3:0] prev_mode = 4'b0001;
   ev_kind_t   seen_kind;
   ev_t        ev;
   start_t     st;

   task automatic fire_done(input logic [1:0] op);
      case (op)
         2'd0:    resp_3x3 = 1'b1;
         2'd1:    resp_1x1 = 1'b1;
         default: resp_mp  = 1'b1;
      endcase
   endtask

   initial begin : monitor
      resp_3x3 = 1'b0;
      resp_1x1 = 1'b0;
      resp_mp  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         resp_3x3 = 1'b0;
         resp_1x1 = 1'b0;
         resp_mp  = 1'b0;
         if (!rstn) begin
            prev_mode = 4'b0001;
            resp_cnt  = 0;
            continue;
         end
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) fire_done(resp_op);
         end

         check("mode_onehot", 32'($onehot(mode)), 32'd1);
         check("enables_vs_mode", 32'({maxpool_en, conv_1x1_en, conv_3x3_en}), 32'(mode[3:1]));
         if (mode != prev_mode)
            check("mode_via_idle", 32'(mode == 4'b0001 || prev_mode == 4'b0001), 32'd1);
         prev_mode = mode;

         if (unit_start) begin
            check("start_expected", 32'(start_q.size() > 0), 32'd1);
            if (start_q.size() > 0) begin
               st = start_q.pop_front();
               check("start_mode", 32'(mode), 32'(4'b0001 << (st.op + 2'd1)));
               start_cyc = cyc;
               lat_exp   = ((st.delay == 0) ? 1 : st.delay) + 1;
               if (st.resp) begin
                  resp_op  = st.op;
                  resp_cnt = st.delay;
                  if (st.delay == 0) fire_done(st.op);
               end
            end
         end

         if (layer_done || err_illegal || timeout) begin
            seen_kind = layer_done ? EV_DONE : (err_illegal ? EV_ERR : EV_TMO);
            check("single_event", 32'(layer_done) + 32'(err_illegal) + 32'(timeout), 32'd1);
            check("event_expected", 32'(ev_q.size() > 0), 32'd1);
            if (ev_q.size() > 0) begin
               ev = ev_q.pop_front();
               check("event_kind", 32'(seen_kind), 32'(ev.kind));
               check("done_tag", 32'(done_tag), 32'(ev.tag));
            end
            check("event_mode_idle", 32'(mode), 32'h1);
            if (seen_kind == EV_DONE)
               check("done_latency", 32'(cyc - start_cyc), 32'(lat_exp));
            else if (seen_kind == EV_TMO)
               check("timeout_latency", 32'(cyc - start_cyc), 32'(TO_CYC + 1));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] op, input logic [TAG_W-1:0] tag, input bit exp_start,
                       input bit resp, input int delay, input ev_kind_t kind);
      int n = 0;
      while (!desc_ready && n < 300) begin
         step();
         n++;
      end
      check("push_ready", 32'(desc_ready), 32'd1);
      desc_valid = 1'b1;
      desc_op    = op;
      desc_tag   = tag;
      if (exp_start) start_q.push_back('{op: op, resp: resp, delay: delay});
      if (kind != EV_NONE) ev_q.push_back('{kind: kind, tag: tag});
      step();
      desc_valid = 1'b0;
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      while (!unit_start && n < budget) begin
         step();
         n++;
      end
      check("wait_start", 32'(unit_start), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || ev_q.size() != 0 || start_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check("wait_idle", 32'(!busy && ev_q.size() == 0 && start_q.size() == 0), 32'd1);
      step();
   endtask

   initial begin : stimulus
      rstn       = 1'b0;
      desc_valid = 1'b0;
      desc_op    = 2'd0;
      desc_tag   = '0;
      abort      = 1'b0;
      stray_3x3  = 1'b0;

      repeat (2) step();
      check("rst_mode", 32'(mode), 32'h1);
      check("rst_enables", 32'({maxpool_en, conv_1x1_en, conv_3x3_en}), 32'h0);
      check("rst_pulses", 32'({unit_start, layer_done, err_illegal, timeout}), 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(desc_ready), 32'd1);
      check("rst_done_tag", 32'(done_tag), 32'h0);
      rstn = 1'b1;
      step();

      // Single 3x3 layer, done 5 cycles after start
      push(2'd0, 8'h11, 1'b1, 1'b1, 5, EV_DONE);
      check("t1_pop_mode", 32'(mode), 32'h1);
      check("t1_pop_busy", 32'(busy), 32'd1);
      step();
      check("t1_sw1_mode", 32'(mode), 32'h2);
      check("t1_sw1_en", 32'(conv_3x3_en), 32'd1);
      check("t1_sw1_start", 32'(unit_start), 32'd0);
      step();
      check("t1_sw2_mode", 32'(mode), 32'h2);
      check("t1_sw2_start", 32'(unit_start), 32'd0);
      step();
      check("t1_start", 32'(unit_start), 32'd1);
      step();
      check("t1_start_once", 32'(unit_start), 32'd0);
      wait_idle(50);

      // Back-to-back ops 1,2,0
      push(2'd1, 8'h01, 1'b1, 1'b1, 3, EV_DONE);
      push(2'd2, 8'h02, 1'b1, 1'b1, 3, EV_DONE);
      push(2'd0, 8'h03, 1'b1, 1'b1, 3, EV_DONE);
      wait_idle(100);

      // Fill the FIFO while a long layer runs
      push(2'd0, 8'h21, 1'b1, 1'b1, 30, EV_DONE);
      push(2'd1, 8'h22, 1'b1, 1'b1, 2, EV_DONE);
      push(2'd2, 8'h23, 1'b1, 1'b1, 2, EV_DONE);
      push(2'd0, 8'h24, 1'b1, 1'b1, 2, EV_DONE);
      push(2'd1, 8'h25, 1'b1, 1'b1, 2, EV_DONE);
      check("fill_ready_low", 32'(desc_ready), 32'd0);
      desc_valid = 1'b1;
      desc_op    = 2'd0;
      desc_tag   = 8'h26;
      for (int i = 0; i < 3; i++) begin
         step();
         check("fill_ready_held", 32'(desc_ready), 32'd0);
      end
      desc_valid = 1'b0;
      begin
         int n = 0;
         while (!desc_ready && n < 100) begin
            step();
            n++;
         end
      end
      check("fill_ready_back", 32'(desc_ready), 32'd1);
      wait_idle(300);

      // Illegal op followed by max-pool, done in the START cycle
      push(2'd3, 8'h7F, 1'b0, 1'b0, 0, EV_ERR);
      push(2'd2, 8'h80, 1'b1, 1'b1, 0, EV_DONE);
      wait_idle(50);

      // Abort during RUN with a foreign done and a same-cycle push
      push(2'd1, 8'h44, 1'b1, 1'b0, 0, EV_NONE);
      push(2'd0, 8'h45, 1'b0, 1'b0, 0, EV_NONE);
      wait_start(20);
      step();
      stray_3x3 = 1'b1;
      step();
      stray_3x3  = 1'b0;
      check("abort_still_run", 32'(mode), 32'h4);
      abort      = 1'b1;
      desc_valid = 1'b1;
      desc_op    = 2'd0;
      desc_tag   = 8'h46;
      step();
      abort      = 1'b0;
      desc_valid = 1'b0;
      check("abort_mode", 32'(mode), 32'h1);
      check("abort_enables", 32'({maxpool_en, conv_1x1_en, conv_3x3_en}), 32'h0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(desc_ready), 32'd1);
      check("abort_no_done", 32'(layer_done), 32'd0);
      repeat (5) step();
      check("abort_stays_idle", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of a max-pool layer
      push(2'd2, 8'h55, 1'b1, 1'b0, 0, EV_NONE);
      wait_start(20);
      step();
      #3;
      rstn = 1'b0;
      #1;
      check("mid_rst_mode", 32'(mode), 32'h1);
      check("mid_rst_en", 32'(maxpool_en), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_tag", 32'(done_tag), 32'h0);
      step();
      rstn = 1'b1;
      step();
      check("post_rst_ready", 32'(desc_ready), 32'd1);

`ifdef EPU_SEQ_TIMEOUT_EN
      // Watchdog expiry, then the queued layer proceeds
      push(2'd0, 8'h60, 1'b1, 1'b0, 0, EV_TMO);
      push(2'd1, 8'h61, 1'b1, 1'b1, 2, EV_DONE);
      wait_idle(100);
`endif

      check("queues_drained", 32'(ev_q.size() + start_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "bench watchdog expired");
   end

endmodule
